// File: rtl/i2s_rx_deserializer_if.sv
// I2S receive bundle: serial pins in, aligned
// left/right sample pair and status strobes out.
interface i2s_rx_deserializer_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  I2S_BCK;
  logic                  I2S_DATA;
  logic                  I2S_WS;
  logic [DATA_WIDTH-1:0] APDATA_LEFT_o;
  logic [DATA_WIDTH-1:0] APDATA_RIGHT_o;
  logic                  APDATA_VALID_o;
  logic                  FRAME_ERR_o;

  modport master (
    output I2S_BCK,
    output I2S_DATA,
    output I2S_WS,
    input  APDATA_LEFT_o,
    input  APDATA_RIGHT_o,
    input  APDATA_VALID_o,
    input  FRAME_ERR_o
  );

  modport slave (
    input  I2S_BCK,
    input  I2S_DATA,
    input  I2S_WS,
    output APDATA_LEFT_o,
    output APDATA_RIGHT_o,
    output APDATA_VALID_o,
    output FRAME_ERR_o
  );
endinterface

// File: rtl/i2s_rx_deserializer.sv
// Oversampling I2S receiver: deserializes the
// external stream into one left+right pair per frame.
module i2s_rx_deserializer #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic        LEFT_WS_LEVEL = 1'b0
) (
  input logic                  AMCLK_i,
  input logic                  ARST,
  i2s_rx_deserializer_if.slave bus
);

  typedef enum logic {
    WAIT_SYNC,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] bck_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic bck_prev, bck_rise;
  logic data_bit, ws_bit;

  logic [5:0] cnt_q, cnt_d, cnt_inc;
  logic [DATA_WIDTH-1:0] cap_q, cap_d, cap_w;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] right_q, right_d;
  logic ws_prev_q, ws_prev_d;
  logic left_ok_q, left_ok_d;
  logic valid_q, valid_d;
  logic err_q, err_d;

  // Edge detect and samples are registered together
  always_ff @(posedge AMCLK_i or posedge ARST) begin
    if (ARST) begin
      bck_sync  <= '0;
      data_sync <= '0;
      ws_sync   <= '0;
      bck_prev  <= 1'b0;
      bck_rise  <= 1'b0;
      data_bit  <= 1'b0;
      ws_bit    <= 1'b0;
    end else begin
      bck_sync  <= {bck_sync[SYNC_STAGES-2:0], bus.I2S_BCK};
      data_sync <= {data_sync[SYNC_STAGES-2:0], bus.I2S_DATA};
      ws_sync   <= {ws_sync[SYNC_STAGES-2:0], bus.I2S_WS};
      bck_prev  <= bck_sync[SYNC_STAGES-1];
      bck_rise  <= bck_sync[SYNC_STAGES-1] & ~bck_prev;
      data_bit  <= data_sync[SYNC_STAGES-1];
      ws_bit    <= ws_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge AMCLK_i or posedge ARST) begin
    if (ARST) begin
      state_q   <= WAIT_SYNC;
      cnt_q     <= '0;
      cap_q     <= '0;
      hold_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      ws_prev_q <= LEFT_WS_LEVEL;
      left_ok_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      hold_q    <= hold_d;
      left_q    <= left_d;
      right_q   <= right_d;
      ws_prev_q <= ws_prev_d;
      left_ok_q <= left_ok_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    hold_d    = hold_q;
    left_d    = left_q;
    right_d   = right_q;
    ws_prev_d = ws_prev_q;
    left_ok_d = left_ok_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    cnt_inc   = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
    cap_w     = cap_q;
    // Bits past DATA_WIDTH match no index and drop out
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if ({26'd0, cnt_q} == 32'(DATA_WIDTH - 1 - i)) begin
        cap_w[i] = data_bit;
      end
    end
    if (bck_rise) begin
      ws_prev_d = ws_bit;
      if (ws_bit != ws_prev_q) begin
        cap_d = '0;
        cnt_d = '0;
        unique case (state_q)
          WAIT_SYNC: state_d = RUN;
          RUN: begin
            err_d = ({26'd0, cnt_inc} < 32'(DATA_WIDTH));
            if (ws_prev_q == LEFT_WS_LEVEL) begin
              hold_d    = cap_w;
              left_ok_d = 1'b1;
            end else if (left_ok_q) begin
              left_d    = hold_q;
              right_d   = cap_w;
              valid_d   = 1'b1;
              left_ok_d = 1'b0;
            end
          end
        endcase
      end else begin
        cap_d = cap_w;
        cnt_d = cnt_inc;
      end
    end
  end

  assign bus.APDATA_LEFT_o  = left_q;
  assign bus.APDATA_RIGHT_o = right_q;
  assign bus.APDATA_VALID_o = valid_q;
  assign bus.FRAME_ERR_o    = err_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer: framing,
// latency, short slots, reset recovery, stalled BCK.
module tb_i2s_rx_deserializer;

  localparam int DW = 16;
  localparam int SS = 2;

  logic clk  = 1'b0;
  logic arst = 1'b0;

  i2s_rx_deserializer_if #(.DATA_WIDTH(DW)) bus ();

  i2s_rx_deserializer #(
    .DATA_WIDTH   (DW),
    .SYNC_STAGES  (SS),
    .LEFT_WS_LEVEL(1'b0)
  ) dut (
    .AMCLK_i(clk),
    .ARST   (arst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int last_rise = 0;
  int v0, e0;
  logic [DW-1:0] vl [64];
  logic [DW-1:0] vr [64];
  int vcyc [64];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (bus.APDATA_VALID_o === 1'b1) begin
      vl[valid_cnt % 64]   = bus.APDATA_LEFT_o;
      vr[valid_cnt % 64]   = bus.APDATA_RIGHT_o;
      vcyc[valid_cnt % 64] = cyc;
      valid_cnt = valid_cnt + 1;
    end
    if (bus.FRAME_ERR_o === 1'b1) err_cnt = err_cnt + 1;
  end

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1
  task automatic send_bit(logic ws, logic d, int half);
    bus.I2S_BCK  = 1'b0;
    bus.I2S_WS   = ws;
    bus.I2S_DATA = d;
    repeat (half) @(posedge clk);
    #1;
    bus.I2S_BCK = 1'b1;
    last_rise   = cyc;
    repeat (half) @(posedge clk);
    #1;
  endtask

  task automatic send_slot(logic [15:0] w, int n, logic ws,
                           int half, int arst_bit,
                           logic arst_val);
    for (int i = 0; i < n; i++) begin
      logic d;
      logic wsb;
      if (i == arst_bit) begin
        arst = arst_val;
        if (arst_val) begin
          #1;
          check("rst_left", 32'(bus.APDATA_LEFT_o), 0);
          check("rst_right", 32'(bus.APDATA_RIGHT_o), 0);
          check("rst_valid", 32'(bus.APDATA_VALID_o), 0);
          check("rst_err", 32'(bus.FRAME_ERR_o), 0);
        end
      end
      d   = (i < 16) ? w[15-i] : i[0];
      wsb = (i == n - 1) ? ~ws : ws;
      send_bit(wsb, d, half);
    end
  endtask

  task automatic send_frame(logic [15:0] l, logic [15:0] r,
                            int n, int half);
    send_slot(l, n, 1'b0, half, -1, 1'b0);
    send_slot(r, n, 1'b1, half, -1, 1'b0);
  endtask

  task automatic flush();
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.I2S_BCK  = 1'b0;
    bus.I2S_DATA = 1'b0;
    bus.I2S_WS   = 1'b0;
    #1 arst = 1'b1;
    #2;
    check("reset_left", 32'(bus.APDATA_LEFT_o), 0);
    check("reset_right", 32'(bus.APDATA_RIGHT_o), 0);
    check("reset_valid", 32'(bus.APDATA_VALID_o), 0);
    check("reset_err", 32'(bus.FRAME_ERR_o), 0);
    @(posedge clk);
    #1 arst = 1'b0;

    // 32-bit slots, BCK = AMCLK/8, first frame syncs
    v0 = valid_cnt;
    e0 = err_cnt;
    repeat (4) send_frame(16'h1234, 16'hABCD, 32, 4);
    flush();
    check("s32_valid_cnt", 32'(valid_cnt - v0), 3);
    check("s32_err_cnt", 32'(err_cnt - e0), 0);
    check("s32_left", 32'(vl[v0 % 64]), 32'h1234);
    check("s32_right", 32'(bus.APDATA_RIGHT_o), 32'hABCD);

    // 16-bit slots, BCK = AMCLK/4, latency
    v0 = valid_cnt;
    e0 = err_cnt;
    repeat (3) send_frame(16'h8001, 16'h7FFE, 16, 2);
    flush();
    check("s16_valid_cnt", 32'(valid_cnt - v0), 3);
    check("s16_err_cnt", 32'(err_cnt - e0), 0);
    check("s16_left", 32'(bus.APDATA_LEFT_o), 32'h8001);
    check("s16_right", 32'(bus.APDATA_RIGHT_o), 32'h7FFE);
    check("s16_latency",
          32'(vcyc[(valid_cnt - 1) % 64] - last_rise), SS + 2);

    // reset through left slot, release mid right slot
    v0 = valid_cnt;
    send_slot(16'h1111, 16, 1'b0, 2, 0, 1'b1);
    send_slot(16'h2222, 16, 1'b1, 2, 5, 1'b0);
    repeat (2) send_frame(16'h0F0F, 16'hF0F0, 16, 2);
    flush();
    check("midrst_valid_cnt", 32'(valid_cnt - v0), 2);
    check("midrst_first_l", 32'(vl[v0 % 64]), 32'h0F0F);
    check("midrst_first_r", 32'(vr[v0 % 64]), 32'hF0F0);

    // 12-bit slots are zero-padded and flagged
    v0 = valid_cnt;
    e0 = err_cnt;
    repeat (3) send_frame(16'hABC0, 16'h1230, 12, 2);
    flush();
    check("s12_valid_cnt", 32'(valid_cnt - v0), 3);
    check("s12_err_cnt", 32'(err_cnt - e0), 6);
    check("s12_left", 32'(bus.APDATA_LEFT_o), 32'hABC0);
    check("s12_right", 32'(bus.APDATA_RIGHT_o), 32'h1230);

    // async reset at bit 8 of a left slot
    v0 = valid_cnt;
    send_slot(16'hFFFF, 16, 1'b0, 2, 8, 1'b1);
    send_slot(16'h0000, 16, 1'b1, 2, 0, 1'b0);
    repeat (2) send_frame(16'h5A5A, 16'h3C3C, 16, 2);
    flush();
    check("bit8rst_valid_cnt", 32'(valid_cnt - v0), 2);
    check("bit8rst_first_l", 32'(vl[v0 % 64]), 32'h5A5A);
    check("bit8rst_first_r", 32'(vr[v0 % 64]), 32'h3C3C);

    // BCK stopped low for 10 frames while WS/DATA wiggle
    v0 = valid_cnt;
    e0 = err_cnt;
    bus.I2S_BCK = 1'b0;
    for (int i = 0; i < 10 * 64; i++) begin
      bus.I2S_WS   = ((i / 32) % 2) == 1;
      bus.I2S_DATA = $urandom_range(1, 0) == 1;
      repeat (8) @(posedge clk);
    end
    #1;
    flush();
    check("stall_valid_cnt", 32'(valid_cnt - v0), 0);
    check("stall_err_cnt", 32'(err_cnt - e0), 0);
    check("stall_left", 32'(bus.APDATA_LEFT_o), 32'h5A5A);
    check("stall_right", 32'(bus.APDATA_RIGHT_o), 32'h3C3C);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
